// File: rtl/design05_arbiter.sv
// Two-requester round-robin front end for a single start/check design instance.
// One transaction in flight; a watchdog turns a stalled START or CHECK into an error response.
module design05_arbiter #(
  parameter int WIDTH   = 9,
  parameter int TIMEOUT = 255
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [WIDTH-1:0] req0_c,
  input  logic [WIDTH-1:0] req0_d,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH-1:0] rsp0_result,
  output logic [WIDTH-1:0] rsp0_check,
  output logic             rsp0_err,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [WIDTH-1:0] req1_c,
  input  logic [WIDTH-1:0] req1_d,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp1_result,
  output logic [WIDTH-1:0] rsp1_check,
  output logic             rsp1_err,
  output logic             busy,
  output logic [WIDTH-1:0] d_start_a,
  output logic [WIDTH-1:0] d_start_b,
  output logic             d_EN_start,
  input  logic             d_st_ready,
  output logic [WIDTH-1:0] d_result_c,
  input  logic [WIDTH-1:0] d_result,
  input  logic             d_res_ready,
  output logic [WIDTH-1:0] d_check_d,
  output logic             d_EN_check,
  input  logic [WIDTH-1:0] d_check,
  input  logic             d_ch_ready,
  output logic [1:0]       dbg_state
);

  // Handshakes: a transfer fires on the cycle where valid and ready are both high;
  // reqN_ready and the design EN_* strobes are combinational from the current state.
  typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, CHECK = 2'd2, RESP = 2'd3} state_e;

  localparam logic [7:0] TMO = 8'(TIMEOUT);

  state_e           state_q, state_d;
  logic             grant_q, grant_d;
  logic             last_grant_q, last_grant_d;
  logic [WIDTH-1:0] op_a_q, op_a_d, op_b_q, op_b_d, op_c_q, op_c_d, op_d_q, op_d_d;
  logic [WIDTH-1:0] result_q, result_d, chk_q, chk_d;
  logic             err_q, err_d;
  logic [7:0]       timer_q, timer_d;

  logic             win;
  logic             ch_fire;
  logic             rsp_take;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      op_a_q       <= '0;
      op_b_q       <= '0;
      op_c_q       <= '0;
      op_d_q       <= '0;
      result_q     <= '0;
      chk_q        <= '0;
      err_q        <= 1'b0;
      timer_q      <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      op_c_q       <= op_c_d;
      op_d_q       <= op_d_d;
      result_q     <= result_d;
      chk_q        <= chk_d;
      err_q        <= err_d;
      timer_q      <= timer_d;
    end
  end

  // A tie goes to the requester that was not served last.
  assign win      = (req0_valid & req1_valid) ? ~last_grant_q : req1_valid;
  assign ch_fire  = d_ch_ready & d_res_ready;
  assign rsp_take = grant_q ? rsp1_ready : rsp0_ready;

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    op_c_d       = op_c_q;
    op_d_d       = op_d_q;
    result_d     = result_q;
    chk_d        = chk_q;
    err_d        = err_q;
    timer_d      = timer_q;

    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    rsp0_valid  = 1'b0;
    rsp0_result = '0;
    rsp0_check  = '0;
    rsp0_err    = 1'b0;
    rsp1_valid  = 1'b0;
    rsp1_result = '0;
    rsp1_check  = '0;
    rsp1_err    = 1'b0;
    d_start_a   = '0;
    d_start_b   = '0;
    d_EN_start  = 1'b0;
    d_result_c  = '0;
    d_check_d   = '0;
    d_EN_check  = 1'b0;

    case (state_q)
      IDLE: begin
        // Ready is held off while reset is asserted so every output reads 0.
        if ((req0_valid | req1_valid) && !RST) begin
          req0_ready = ~win;
          req1_ready = win;
          grant_d    = win;
          op_a_d     = win ? req1_a : req0_a;
          op_b_d     = win ? req1_b : req0_b;
          op_c_d     = win ? req1_c : req0_c;
          op_d_d     = win ? req1_d : req0_d;
          timer_d    = '0;
          state_d    = START;
        end
      end
      START: begin
        d_start_a  = op_a_q;
        d_start_b  = op_b_q;
        d_EN_start = d_st_ready;
        if (d_st_ready) begin
          timer_d = '0;
          state_d = CHECK;
        end else if (timer_q == TMO) begin
          result_d = '0;
          chk_d    = '0;
          err_d    = 1'b1;
          state_d  = RESP;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      CHECK: begin
        d_result_c = op_c_q;
        d_check_d  = op_d_q;
        d_EN_check = ch_fire;
        if (ch_fire) begin
          result_d = d_result;
          chk_d    = d_check;
          err_d    = 1'b0;
          state_d  = RESP;
        end else if (timer_q == TMO) begin
          result_d = '0;
          chk_d    = '0;
          err_d    = 1'b1;
          state_d  = RESP;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      RESP: begin
        if (grant_q) begin
          rsp1_valid  = 1'b1;
          rsp1_result = result_q;
          rsp1_check  = chk_q;
          rsp1_err    = err_q;
        end else begin
          rsp0_valid  = 1'b1;
          rsp0_result = result_q;
          rsp0_check  = chk_q;
          rsp0_err    = err_q;
        end
        if (rsp_take) begin
          last_grant_d = grant_q;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy      = (state_q != IDLE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_design05_arbiter.sv
// Directed bench for design05_arbiter: a table of whole transactions checked cycle by cycle,
// plus hand-written reset sequences. The design side is emulated by the bench.
module tb_design05_arbiter;
  localparam int W  = 9;
  localparam int TO = 4;

  logic         CLK = 1'b0;
  logic         RST;
  logic         req0_valid, req0_ready, req1_valid, req1_ready;
  logic [W-1:0] req0_a, req0_b, req0_c, req0_d, req1_a, req1_b, req1_c, req1_d;
  logic         rsp0_valid, rsp0_ready, rsp0_err, rsp1_valid, rsp1_ready, rsp1_err;
  logic [W-1:0] rsp0_result, rsp0_check, rsp1_result, rsp1_check;
  logic         busy, d_EN_start, d_st_ready, d_res_ready, d_EN_check, d_ch_ready;
  logic [W-1:0] d_start_a, d_start_b, d_result_c, d_result, d_check_d, d_check;
  logic [1:0]   dbg_state;

  design05_arbiter #(.WIDTH(W), .TIMEOUT(TO)) dut (
    .CLK(CLK), .RST(RST),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_c(req0_c), .req0_d(req0_d),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp0_result(rsp0_result), .rsp0_check(rsp0_check), .rsp0_err(rsp0_err),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_c(req1_c), .req1_d(req1_d),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp1_result(rsp1_result), .rsp1_check(rsp1_check), .rsp1_err(rsp1_err),
    .busy(busy),
    .d_start_a(d_start_a), .d_start_b(d_start_b), .d_EN_start(d_EN_start),
    .d_st_ready(d_st_ready), .d_result_c(d_result_c), .d_result(d_result),
    .d_res_ready(d_res_ready), .d_check_d(d_check_d), .d_EN_check(d_EN_check),
    .d_check(d_check), .d_ch_ready(d_ch_ready), .dbg_state(dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1);
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic [1:0]   mask;
    logic [W-1:0] a, b, c, d, res, chk;
    int           st_wait, ch_wait, rr_wait;
    logic         exp_grant;
    logic         exp_err;
  } vec_t;

  vec_t vecs[13];

  // ---------------- scoreboard ----------------
  logic [2*W:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  function automatic vec_t mk(input logic [1:0] m, input logic [W-1:0] a, b, c, d, res, chk,
                              input int st, ch, rr, input logic g, e);
    vec_t v;
    v.mask = m; v.a = a; v.b = b; v.c = c; v.d = d; v.res = res; v.chk = chk;
    v.st_wait = st; v.ch_wait = ch; v.rr_wait = rr; v.exp_grant = g; v.exp_err = e;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_core(input string tag, input logic r0, r1, bsy, ens, enc,
                            input logic [W-1:0] sa, sb, rc, cd);
    chk({tag, ".req0_ready"}, req0_ready, r0);
    chk({tag, ".req1_ready"}, req1_ready, r1);
    chk({tag, ".busy"}, busy, bsy);
    chk({tag, ".en_start"}, d_EN_start, ens);
    chk({tag, ".en_check"}, d_EN_check, enc);
    chk({tag, ".start_a"}, d_start_a, sa);
    chk({tag, ".start_b"}, d_start_b, sb);
    chk({tag, ".result_c"}, d_result_c, rc);
    chk({tag, ".check_d"}, d_check_d, cd);
  endtask

  // data = {err, check, result} of the response expected on the valid side.
  task automatic check_rsp(input string tag, input logic v0, v1, input logic [2*W:0] data);
    logic [2*W:0] d0, d1;
    d0 = v0 ? data : '0;
    d1 = v1 ? data : '0;
    chk({tag, ".rsp0_valid"}, rsp0_valid, v0);
    chk({tag, ".rsp0_result"}, rsp0_result, d0[W-1:0]);
    chk({tag, ".rsp0_check"}, rsp0_check, d0[2*W-1:W]);
    chk({tag, ".rsp0_err"}, rsp0_err, d0[2*W]);
    chk({tag, ".rsp1_valid"}, rsp1_valid, v1);
    chk({tag, ".rsp1_result"}, rsp1_result, d1[W-1:0]);
    chk({tag, ".rsp1_check"}, rsp1_check, d1[2*W-1:W]);
    chk({tag, ".rsp1_err"}, rsp1_err, d1[2*W]);
  endtask

  task automatic check_all_zero(input string tag);
    check_core(tag, 0, 0, 0, 0, 0, '0, '0, '0, '0);
    check_rsp(tag, 0, 0, '0);
  endtask

  // ---------------- driver ----------------
  task automatic drive_req(input vec_t v);
    req0_valid = v.mask[0];
    req1_valid = v.mask[1];
    // The losing side carries inverted operands so a wrong mux select is visible.
    req0_a = v.exp_grant ? ~v.a : v.a;  req1_a = v.exp_grant ? v.a : ~v.a;
    req0_b = v.exp_grant ? ~v.b : v.b;  req1_b = v.exp_grant ? v.b : ~v.b;
    req0_c = v.exp_grant ? ~v.c : v.c;  req1_c = v.exp_grant ? v.c : ~v.c;
    req0_d = v.exp_grant ? ~v.d : v.d;  req1_d = v.exp_grant ? v.d : ~v.d;
  endtask

  task automatic run_txn(input vec_t v, input string tag);
    logic g;
    int   n_low;
    g = v.exp_grant;
    drive_req(v);
    d_st_ready = 1'b1; d_ch_ready = 1'b1; d_res_ready = 1'b1;
    d_result = ~v.res; d_check = ~v.chk;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    #1;
    check_core({tag, ".accept"}, ~g, g, 0, 0, 0, '0, '0, '0, '0);
    check_rsp({tag, ".accept"}, 0, 0, '0);
    exp_q.push_back(v.exp_err ? {1'b1, {W{1'b0}}, {W{1'b0}}} : {1'b0, v.chk, v.res});
    step();

    n_low = (v.st_wait > TO) ? TO + 1 : v.st_wait;
    for (int i = 0; i < n_low; i++) begin
      d_st_ready = 1'b0;
      #1;
      check_core({tag, ".start_wait"}, 0, 0, 1, 0, 0, v.a, v.b, '0, '0);
      step();
    end
    if (v.st_wait <= TO) begin
      d_st_ready = 1'b1;
      #1;
      check_core({tag, ".start_fire"}, 0, 0, 1, 1, 0, v.a, v.b, '0, '0);
      step();
      n_low = (v.ch_wait > TO) ? TO + 1 : v.ch_wait;
      for (int i = 0; i < n_low; i++) begin
        d_ch_ready  = (i % 2 == 0);
        d_res_ready = (i % 2 != 0);
        #1;
        check_core({tag, ".check_wait"}, 0, 0, 1, 0, 0, '0, '0, v.c, v.d);
        step();
      end
      if (v.ch_wait <= TO) begin
        d_ch_ready = 1'b1; d_res_ready = 1'b1;
        d_result = v.res; d_check = v.chk;
        #1;
        check_core({tag, ".check_fire"}, 0, 0, 1, 0, 1, '0, '0, v.c, v.d);
        step();
      end
    end
    d_st_ready = 1'b1; d_ch_ready = 1'b1; d_res_ready = 1'b1;
    d_result = ~v.res; d_check = ~v.chk;

    for (int i = 0; i < v.rr_wait; i++) begin
      rsp0_ready = g;
      rsp1_ready = ~g;
      #1;
      check_core({tag, ".resp_wait"}, 0, 0, 1, 0, 0, '0, '0, '0, '0);
      check_rsp({tag, ".resp_wait"}, ~g, g, exp_q[0]);
      step();
    end
    rsp0_ready = ~g;
    rsp1_ready = g;
    #1;
    check_core({tag, ".resp_take"}, 0, 0, 1, 0, 0, '0, '0, '0, '0);
    check_rsp({tag, ".resp_take"}, ~g, g, exp_q[0]);
    step();
    void'(exp_q.pop_front());
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
  endtask

  // ---------------- test ----------------
  initial begin
    vec_t v;
    vecs[0]  = mk(2'b01, 9'd3,   9'd5,   9'd1,   9'd2,   9'h0ab, 9'h155, 0, 0, 0, 1'b0, 1'b0);
    vecs[1]  = mk(2'b11, 9'd17,  9'd33,  9'd65,  9'd129, 9'h1f0, 9'h00f, 0, 0, 0, 1'b1, 1'b0);
    vecs[2]  = mk(2'b11, 9'd400, 9'd12,  9'd77,  9'd300, 9'h111, 9'h0ee, 0, 0, 0, 1'b0, 1'b0);
    vecs[3]  = mk(2'b11, 9'd9,   9'd500, 9'd250, 9'd6,   9'h1a5, 9'h05a, 0, 0, 0, 1'b1, 1'b0);
    vecs[4]  = mk(2'b11, 9'd256, 9'd128, 9'd64,  9'd32,  9'h003, 9'h1fc, 0, 0, 0, 1'b0, 1'b0);
    vecs[5]  = mk(2'b10, 9'd21,  9'd42,  9'd84,  9'd168, 9'h0c3, 9'h13c, 4, 0, 0, 1'b1, 1'b0);
    vecs[6]  = mk(2'b01, 9'd99,  9'd98,  9'd97,  9'd96,  9'h1e1, 9'h01e, 0, 3, 0, 1'b0, 1'b0);
    vecs[7]  = mk(2'b01, 9'd7,   9'd8,   9'd9,   9'd10,  9'h1ff, 9'h1ff, 0, 5, 0, 1'b0, 1'b1);
    vecs[8]  = mk(2'b01, 9'd11,  9'd22,  9'd33,  9'd44,  9'h099, 9'h166, 0, 0, 0, 1'b0, 1'b0);
    vecs[9]  = mk(2'b10, 9'd55,  9'd66,  9'd77,  9'd88,  9'h155, 9'h0aa, 6, 0, 0, 1'b1, 1'b1);
    vecs[10] = mk(2'b01, 9'd101, 9'd202, 9'd303, 9'd404, 9'h0f0, 9'h10f, 0, 0, 0, 1'b0, 1'b0);
    vecs[11] = mk(2'b11, 9'd510, 9'd1,   9'd255, 9'd257, 9'h13a, 9'h0c5, 0, 0, 6, 1'b1, 1'b0);
    vecs[12] = mk(2'b01, 9'd31,  9'd62,  9'd124, 9'd248, 9'h07e, 9'h181, 0, 0, 0, 1'b0, 1'b0);

    // Reset with every input pulling: outputs must all read 0.
    RST = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_a = 9'h1ff; req0_b = 9'h1ff; req0_c = 9'h1ff; req0_d = 9'h1ff;
    req1_a = 9'h1ff; req1_b = 9'h1ff; req1_c = 9'h1ff; req1_d = 9'h1ff;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    d_st_ready = 1'b1; d_ch_ready = 1'b1; d_res_ready = 1'b1;
    d_result = 9'h1ff; d_check = 9'h1ff;
    step();
    check_all_zero("reset");
    step();
    RST = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    step();

    for (int i = 0; i < 13; i++) begin
      run_txn(vecs[i], $sformatf("v%0d", i));
    end

    // Reset while in CHECK aborts the transaction with no response.
    v = mk(2'b01, 9'd70, 9'd71, 9'd72, 9'd73, 9'h0aa, 9'h055, 0, 0, 0, 1'b0, 1'b0);
    drive_req(v);
    #1;
    check_core("mid.accept", 1, 0, 0, 0, 0, '0, '0, '0, '0);
    step();
    #1;
    check_core("mid.start", 0, 0, 1, 1, 0, v.a, v.b, '0, '0);
    step();
    d_ch_ready = 1'b0; d_res_ready = 1'b0;
    #1;
    check_core("mid.check", 0, 0, 1, 0, 0, '0, '0, v.c, v.d);
    #2;
    RST = 1'b1;
    req1_valid = 1'b1;
    d_ch_ready = 1'b1; d_res_ready = 1'b1; rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    #1;
    check_all_zero("mid.reset_now");
    step();
    check_all_zero("mid.reset_held");
    RST = 1'b0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;

    // After reset a tie goes to requester 0, then alternates.
    run_txn(mk(2'b11, 9'd300, 9'd301, 9'd302, 9'd303, 9'h123, 9'h0dc, 0, 0, 0, 1'b0, 1'b0), "post0");
    run_txn(mk(2'b11, 9'd5,   9'd6,   9'd7,   9'd8,   9'h042, 9'h1bd, 0, 0, 0, 1'b1, 1'b0), "post1");

    req0_valid = 1'b0; req1_valid = 1'b0;
    #1;
    check_all_zero("final_idle");
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
